// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the Gray-converter front-end scheduler.
package conv_sched_pkg;

    localparam int DATA_W      = 4;
    localparam int TIMEOUT_DEF = 31;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_DRIVE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

endpackage

// File: rtl/conv_scheduler_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, with wrap.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any_gnt
);

    // Walk the requests starting at the pointer; the first hit wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any_gnt && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
                any_gnt  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_scheduler.sv
// Shares one bit-serial binary-to-Gray converter between NREQ requesters.
// One job in flight: clear datapath, present operand, start, wait for done
// (bounded by TIMEOUT), capture the bus and return the tagged result.
module conv_scheduler
    import conv_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [IDW-1:0]           rsp_id,
    output logic                     rsp_err,
    input  logic                     rsp_ready,
    output logic                     busy,
    output logic                     cv_rst,
    output logic                     cv_start,
    output logic [DATA_W-1:0]        cv_bus_out,
    output logic                     cv_bus_oe,
    input  logic [DATA_W-1:0]        cv_bus_in,
    input  logic                     cv_done
);

    state_t            state;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    job_id;
    logic [DATA_W-1:0] job_data;
    logic [7:0]        cnt;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_idx;
    logic              any_gnt;

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // Accept is only offered while idle and out of reset, so a grant always starts a job.
    assign req_ready = (rst && state == S_IDLE) ? gnt : '0;

    // Job sequencer; every output is registered against the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            job_id     <= '0;
            job_data   <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            cv_rst     <= 1'b1;
            cv_start   <= 1'b0;
            cv_bus_oe  <= 1'b0;
            cv_bus_out <= '0;
        end else begin
            cv_rst   <= 1'b0;
            cv_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_gnt) begin
                        job_data <= req_data[gnt_idx*DATA_W +: DATA_W];
                        job_id   <= gnt_idx;
                        ptr      <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                        cv_rst   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_CLR;
                    end
                end
                S_CLR: begin
                    // Datapath has left its sticky done state, so the bus is ours.
                    cv_bus_oe  <= 1'b1;
                    cv_bus_out <= job_data;
                    cv_start   <= 1'b1;
                    state      <= S_DRIVE;
                end
                S_DRIVE: begin
                    // Keep the operand on the bus through the datapath load cycle.
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    cv_bus_oe  <= 1'b0;
                    cv_bus_out <= '0;
                    cnt        <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (cv_done) begin
                        rsp_data  <= cv_bus_in;
                        rsp_err   <= 1'b0;
                        rsp_id    <= job_id;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (cnt == 8'(TIMEOUT)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= job_id;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The scheduler only drives the shared bus while presenting the operand.
    a_bus_oe: assert property (@(posedge clk) disable iff (!rst)
        cv_bus_oe |-> (state == S_DRIVE || state == S_HOLD));

endmodule

// File: tb/tb_conv_scheduler.sv
// Scoreboard bench for conv_scheduler with a behavioural Gray datapath.
module tb_conv_scheduler;
    import conv_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 31;
    localparam int IDW  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [4*NREQ-1:0] req_data;
    logic [NREQ-1:0]  req_ready;
    logic             rsp_valid;
    logic [3:0]       rsp_data;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_err;
    logic             rsp_ready;
    logic             busy;
    logic             cv_rst;
    logic             cv_start;
    logic [3:0]       cv_bus_out;
    logic             cv_bus_oe;
    logic [3:0]       cv_bus_in;
    logic             cv_done;

    conv_scheduler #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy),
        .cv_rst(cv_rst), .cv_start(cv_start), .cv_bus_out(cv_bus_out),
        .cv_bus_oe(cv_bus_oe), .cv_bus_in(cv_bus_in), .cv_done(cv_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Datapath model: latches operand on start, raises sticky done dp_lat cycles later
    // (dp_lat==0 never finishes), then drives the Gray code onto the bus.
    int         dp_lat = 3;
    int         dp_cnt = 0;
    logic       dp_run = 1'b0;
    logic       dp_done = 1'b0;
    logic [3:0] dp_val = 4'h0;

    always @(posedge clk) begin
        if (cv_rst) begin
            dp_run  <= 1'b0;
            dp_done <= 1'b0;
            dp_cnt  <= 0;
        end else if (cv_start) begin
            dp_run <= 1'b1;
            dp_cnt <= 0;
            dp_val <= cv_bus_out;
        end else if (dp_run && !dp_done) begin
            dp_cnt <= dp_cnt + 1;
            if (dp_lat != 0 && dp_cnt + 1 >= dp_lat) dp_done <= 1'b1;
        end
    end

    assign cv_done   = dp_done;
    assign cv_bus_in = cv_bus_oe ? cv_bus_out : (dp_done ? gray4(dp_val) : 4'h0);

    // Scoreboard: push on accepted request, pop on accepted response.
    logic [6:0] sb[$];
    int         oe_clash = 0;

    always @(negedge clk) begin
        logic [3:0] d;
        logic [6:0] e;
        if (rst === 1'b1) begin
            for (int k = 0; k < NREQ; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    d = req_data[4*k +: 4];
                    sb.push_back({2'(k), (dp_lat == 0) ? 4'h0 : gray4(d), 1'(dp_lat == 0)});
                end
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_pending", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_id_data_err", {rsp_id, rsp_data, rsp_err}, e);
                end
            end
            if (cv_bus_oe && dp_done) oe_clash++;
        end
    end

    // Cycle tracker shared by the directed tests.
    int   cyc = 0;
    int   t_grant = -1, t_rsp = -1, t_acc = -1, t_cvrst = -1;
    int   rdy_cnt = 0, cvrst_cnt = 0;
    logic prev_rv = 1'b0;
    int   gid_q[$];

    task automatic clr_trk();
        t_grant = -1; t_rsp = -1; t_acc = -1; t_cvrst = -1;
        rdy_cnt = 0; cvrst_cnt = 0;
        gid_q.delete();
    endtask

    task automatic step();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        if (req_ready != 0) begin rdy_cnt++; t_grant = cyc; end
        for (int k = 0; k < NREQ; k++) if (hs[k]) gid_q.push_back(k);
        if (cv_rst === 1'b1) begin cvrst_cnt++; t_cvrst = cyc; end
        if (rsp_valid === 1'b1 && !prev_rv) t_rsp = cyc;
        prev_rv = (rsp_valid === 1'b1);
        if (rsp_valid === 1'b1 && rsp_ready) t_acc = cyc;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs;
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((busy || rsp_valid || req_valid != 0) && n < 400);
        check({tag, "_drain"}, 32'(n < 400), 1);
    endtask

    task automatic check_rst_state(input string tag);
        check(tag, {rsp_valid, rsp_err, rsp_data, rsp_id, busy, cv_start,
                    cv_bus_oe, cv_bus_out, cv_rst, req_ready}, {16'h0001, 4'h0});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        sb.delete();
        repeat (3) step();
        check_rst_state("reset_state");
        rst = 1'b1;
        step();
        check("cvrst_after_reset", 32'(cv_rst), 0);
        clr_trk();
    endtask

    initial begin
        logic [6:0] held;
        int         n;
        int         hold_bad;
        rst = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b1;

        do_reset();

        // single job from requester 2
        req_data[11:8] = 4'b1011;
        req_valid[2] = 1'b1;
        drain("t1");
        check("t1_ready_cycles", rdy_cnt, 1);
        check("t1_gid", (gid_q.size() > 0) ? gid_q[0] : -1, 2);
        check("t1_cvrst_cnt", cvrst_cnt, 1);
        check("t1_cvrst_at", t_cvrst - t_grant, 1);
        check("t1_rsp_lat", t_rsp - t_grant, 7);
        check("t1_data", rsp_data, 4'b1110);
        check("t1_id", rsp_id, 2);

        // four simultaneous requests after reset
        do_reset();
        req_data = {4'd4, 4'd3, 4'd2, 4'd1};
        req_valid = 4'hF;
        drain("t2");
        check("t2_ngrants", gid_q.size(), 4);
        for (int i = 0; i < 4; i++) check("t2_order", (gid_q.size() > i) ? gid_q[i] : -1, i);
        clr_trk();
        req_data[3:0] = 4'd9; req_data[15:12] = 4'd10;
        req_valid = 4'b1001;
        drain("t2b");
        check("t2b_first", (gid_q.size() > 0) ? gid_q[0] : -1, 0);
        check("t2b_second", (gid_q.size() > 1) ? gid_q[1] : -1, 3);

        // timeout, then a normal job
        clr_trk();
        dp_lat = 0;
        req_data[7:4] = 4'd5;
        req_valid = 4'b0010;
        drain("t3");
        check("t3_tmo_lat", t_rsp - t_grant, 4 + TMO + 1);
        check("t3_err", rsp_err, 1);
        check("t3_data", rsp_data, 0);
        clr_trk();
        dp_lat = 3;
        req_valid = 4'b0010;
        drain("t3b");
        check("t3b_err", rsp_err, 0);
        check("t3b_data", rsp_data, 4'b0111);
        check("t3b_lat", t_rsp - t_grant, 7);

        // response back-pressure with another request pending
        clr_trk();
        rsp_ready = 1'b0;
        req_data[3:0] = 4'd12;
        req_valid = 4'b0001;
        n = 0;
        while (!rsp_valid && n < 60) begin step(); n++; end
        check("t4_rsp_seen", 32'(rsp_valid), 1);
        req_data[11:8] = 4'd6;
        req_valid[2] = 1'b1;
        held = {rsp_id, rsp_data, rsp_err};
        check("t4_held", held, {2'd0, 4'b1010, 1'b0});
        hold_bad = 0;
        repeat (10) begin
            step();
            if ({rsp_id, rsp_data, rsp_err} !== held || req_ready != 0 || !rsp_valid) hold_bad++;
        end
        check("t4_stable", hold_bad, 0);
        rsp_ready = 1'b1;
        step();
        step();
        check("t4_grant_after_acc", t_grant - t_acc, 1);
        drain("t4");

        // reset during WAIT
        clr_trk();
        req_data[7:4] = 4'd3;
        req_valid = 4'b0010;
        n = 0;
        while (gid_q.size() == 0 && n < 20) begin step(); n++; end
        repeat (4) step();
        rst = 1'b0;
        sb.delete();
        step();
        check_rst_state("t5_mid_reset");
        check("t5_busy", 32'(busy), 0);
        step();
        rst = 1'b1;
        hold_bad = 0;
        repeat (8) begin step(); if (rsp_valid !== 1'b0) hold_bad++; end
        check("t5_no_rsp", hold_bad, 0);
        clr_trk();
        req_data[15:12] = 4'd8;
        req_valid = 4'b1010;
        drain("t5");
        check("t5_first", (gid_q.size() > 0) ? gid_q[0] : -1, 1);
        check("t5_second", (gid_q.size() > 1) ? gid_q[1] : -1, 3);
        check("t5_data", rsp_data, 4'b1100);

        // done arrives in the same cycle the timeout fires
        clr_trk();
        dp_lat = TMO + 1;
        req_data[3:0] = 4'd9;
        req_valid = 4'b0001;
        drain("t6");
        check("t6_err", rsp_err, 0);
        check("t6_data", rsp_data, 4'b1101);
        check("t6_lat", t_rsp - t_grant, 4 + TMO + 1);
        dp_lat = 3;

        check("oe_clash", oe_clash, 0);
        check("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/conv_scheduler.md
# conv_scheduler

Front-end controller for the 4-bit binary-to-Gray bit-serial code-converter datapath. Round-robin arbitration shares one converter between NREQ requesters. For each job the block clears the datapath, drives the operand onto the shared bus, pulses start, waits for done under a timeout, captures the result from the bus, and returns it tagged with the requester id.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 31, max WAIT cycles before a job is aborted (≤ 255)
- IDW, $clog2(NREQ), requester id width (derived)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester job request
- req_data  in  4*NREQ  operand; requester i at bits [4i+3:4i]
- req_ready  out  NREQ  one-hot accept; handshake completes when valid&ready
- rsp_valid  out  1  result available
- rsp_data  out  4  converted code; 4'b0000 on error
- rsp_id  out  IDW  requester that owns the result
- rsp_err  out  1  job timed out
- rsp_ready  in  1  consumer accepts result
- busy  out  1  high in every state except IDLE
- cv_rst  out  1  datapath reset, active-high
- cv_start  out  1  datapath start
- cv_bus_out  out  4  value driven onto datapath bus
- cv_bus_oe  out  1  bus output enable; the top level builds the tri-state from it
- cv_bus_in  in  4  datapath bus read-back
- cv_done  in  1  datapath done

## Operation
- States: IDLE → CLR → DRIVE → HOLD → WAIT → RESP → IDLE.
- IDLE
  - Arbiter grants the first asserted req_valid at or after the priority pointer, searching upward with wrap.
  - req_ready[g] is high combinationally that cycle. Job register latches req_data[g] and g. Next state is CLR.
  - No valid requests: stay in IDLE.
- CLR: cv_rst=1 for exactly one cycle. This returns the datapath from its sticky done state.
- DRIVE: cv_bus_oe=1, cv_bus_out=operand, cv_start=1.
- HOLD: cv_bus_oe=1, cv_bus_out=operand, cv_start=0. This covers the datapath's load cycle.
- WAIT
  - cv_bus_oe=0. Timeout counter increments each cycle from 0.
  - First cycle with cv_done=1: capture cv_bus_in, rsp_err=0, go to RESP.
  - Counter reaches TIMEOUT without done: rsp_data=0, rsp_err=1, go to RESP.
  - cv_done and the timeout in the same cycle: done wins.
- RESP: rsp_valid=1. rsp_data, rsp_id and rsp_err stay stable until rsp_valid&rsp_ready, then go to IDLE.
- Priority pointer becomes winner+1 (mod NREQ), updated only on a grant.
- Requesters hold valid and data until ready. Dropping valid before grant is legal and the request is lost.
- Bus ownership rules:
  - cv_bus_oe is never high in WAIT or RESP.
  - The datapath only drives the bus in its done state, and CLR guarantees it is out of that state before DRIVE.
- Reset (rst=0 at any edge, including mid-job):
  - Next state IDLE. pointer=0, counter=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - cv_start=0, cv_bus_oe=0, cv_bus_out=0.
  - cv_rst=1 while rst is low.
  - The in-flight job is discarded and no response is issued.

## Timing
- All outputs are registered except req_ready, which is combinational from arbiter and state.
- Grant at cycle T (req_ready high). CLR at T+1, DRIVE at T+2, HOLD at T+3, WAIT from T+4.
- cv_done seen at cycle D: rsp_valid rises at D+1.
- Timeout: rsp_valid rises TIMEOUT+1 cycles after WAIT entry.
- Response accepted at cycle R: earliest next grant is R+1. One job in flight; no overlap.
- cv_rst pulses exactly one cycle per job, outside reset.

## Structure
- Package conv_sched_pkg holds:
  - state enum (IDLE, CLR, DRIVE, HOLD, WAIT, RESP), 3-bit
  - DATA_W=4
  - default TIMEOUT
- Sub-module rr_arb (NREQ parameter):
  - inputs: req vector, pointer
  - outputs: one-hot grant, grant index, any_grant
  - purely combinational; the pointer register lives in conv_scheduler.
- The top level instantiates conv_scheduler next to the datapath and owns the tri-state assign from cv_bus_oe.

## Test plan
- Single job: requester 2 sends 4'b1011, Gray datapath model → rsp_data=4'b1110, rsp_id=2, rsp_err=0. req_ready[2] high for exactly one cycle. cv_rst is high at T+1 only.
- Four simultaneous requests (data 1,2,3,4) after reset → grants in order 0,1,2,3. rsp_data 0001, 0011, 0010, 0110. Requester 0 then re-requests together with requester 3 → 0 is served first (pointer=0 after the 3-grant wraps).
- Model never asserts cv_done → rsp_valid exactly TIMEOUT+1 cycles after WAIT entry, rsp_err=1, rsp_data=0. The next job completes normally.
- rsp_ready held low 10 cycles with another request pending → rsp fields stable, no req_ready. Grant occurs the cycle after the response is accepted.
- rst=0 during WAIT → next edge all outputs at reset values, cv_rst=1, busy=0, no response. After rst=1, a new request to requester 3 is granted (pointer=0 search).
- cv_done and the timeout in the same cycle → rsp_err=0 with captured data. Assertion: cv_bus_oe is never high outside DRIVE and HOLD.
